// File: rtl/skeleton_pkg.sv
// Shared types and header helpers for the device-side skeleton blocks.
package skeleton_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StFull,
    StRead
  } skel_state_e;

  localparam logic [3:0] SKEL_ID_ROM         = 4'd3;
  localparam logic [3:0] SKEL_ID_RAM_CAPTURE = 4'd4;

  // 26-bit metadata word: {id, 6'd0, adr_width[5:0], 5'd0, bitwidth_in[4:0]}.
  function automatic logic [25:0] skel_head(input logic [3:0] id,
                                            input int unsigned adr_width,
                                            input int unsigned bitwidth_in);
    logic [5:0] aw;
    logic [4:0] bw;
    aw = adr_width[5:0];
    bw = bitwidth_in[4:0];
    return {id, 6'd0, aw, 5'd0, bw};
  endfunction

endpackage

// File: rtl/skeleton_ram_capture_if.sv
// Host-facing bus of the RAM capture skeleton: sample input, readback output and status.
interface skeleton_ram_capture_if #(
  parameter int unsigned BITWIDTH_SYS  = 16,
  parameter int unsigned BITWIDTH_HEAD = 32,
  parameter int unsigned ADR_WIDTH     = 8
);
  logic                      en;
  logic                      wr_en;
  logic                      trgg_start_read;
  logic [BITWIDTH_SYS-1:0]   data_in;
  logic [BITWIDTH_SYS-1:0]   data_out;
  logic                      data_valid;
  logic [BITWIDTH_HEAD-7:0]  data_head;
  logic [ADR_WIDTH:0]        fill_cnt;
  logic                      full;
  logic                      overflow;
  logic                      rdy;

  modport master (
    output en, wr_en, trgg_start_read, data_in,
    input  data_out, data_valid, data_head, fill_cnt, full, overflow, rdy
  );

  modport slave (
    input  en, wr_en, trgg_start_read, data_in,
    output data_out, data_valid, data_head, fill_cnt, full, overflow, rdy
  );
endinterface

// File: rtl/skeleton_ram_capture_mem.sv
// Simple dual-port RAM: one write port, one synchronous read port with 1-cycle latency.
module skeleton_ram_capture_mem #(
  parameter int unsigned BITWIDTH_IN = 16,
  parameter int unsigned ADR_WIDTH   = 8
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [ADR_WIDTH-1:0]   waddr,
  input  logic [BITWIDTH_IN-1:0] wdata,
  input  logic                   re,
  input  logic [ADR_WIDTH-1:0]   raddr,
  output logic [BITWIDTH_IN-1:0] rdata
);
  logic [BITWIDTH_IN-1:0] mem [2**ADR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/skeleton_ram_capture.sv
// Records host samples into on-chip RAM and replays the buffer on trigger.
module skeleton_ram_capture
  import skeleton_pkg::*;
#(
  parameter int unsigned BITWIDTH_IN   = 16,
  parameter int unsigned BITWIDTH_SYS  = 16,
  parameter int unsigned BITWIDTH_HEAD = 32,
  parameter int unsigned ADR_WIDTH     = 8
) (
  input logic                   clk_sys,
  input logic                   rst,
  skeleton_ram_capture_if.slave bus
);
  localparam int unsigned        Pad      = BITWIDTH_SYS - BITWIDTH_IN;
  localparam logic [ADR_WIDTH:0] DepthCnt = {1'b1, {ADR_WIDTH{1'b0}}};
  localparam logic [ADR_WIDTH:0] CntOne   = (ADR_WIDTH+1)'(1);
  localparam logic [ADR_WIDTH-1:0] PtrOne = ADR_WIDTH'(1);
  localparam logic [25:0]        HeadWord = skel_head(SKEL_ID_RAM_CAPTURE, ADR_WIDTH,
                                                      BITWIDTH_IN);

  skel_state_e             state_q, state_d;
  logic [ADR_WIDTH-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADR_WIDTH-1:0]    rd_ptr_q, rd_ptr_d;
  logic [ADR_WIDTH:0]      fill_cnt_q, fill_cnt_d;
  logic                    overflow_q, overflow_d;
  logic                    rdy_q, rdy_d;
  logic                    ram_vld_q, ram_vld_d;
  logic                    ram_last_q, ram_last_d;
  logic                    data_valid_q, data_valid_d;
  logic [BITWIDTH_SYS-1:0] data_out_q, data_out_d;
  logic                    mem_we;
  logic                    start_read;
  logic [ADR_WIDTH-1:0]    rd_addr;
  logic [ADR_WIDTH:0]      rd_next;
  logic [BITWIDTH_IN-1:0]  ram_rdata;

  skeleton_ram_capture_mem #(
    .BITWIDTH_IN (BITWIDTH_IN),
    .ADR_WIDTH   (ADR_WIDTH)
  ) u_mem (
    .clk   (clk_sys),
    .we    (mem_we & bus.en),
    .waddr (wr_ptr_q),
    .wdata (bus.data_in[BITWIDTH_SYS-1 -: BITWIDTH_IN]),
    .re    (bus.en),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // rd_ptr is the index of the word most recently issued to the RAM; word 0 is
  // issued in the trigger cycle itself so it lands on data_out two cycles later.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fill_cnt_d   = fill_cnt_q;
    overflow_d   = overflow_q;
    rdy_d        = ram_last_q;
    ram_vld_d    = 1'b0;
    ram_last_d   = 1'b0;
    data_valid_d = ram_vld_q;
    data_out_d   = ram_vld_q ? (BITWIDTH_SYS'(ram_rdata) << Pad) : data_out_q;
    mem_we       = 1'b0;
    start_read   = 1'b0;
    rd_addr      = '0;
    rd_next      = {1'b0, rd_ptr_q} + CntOne;

    unique case (state_q)
      StIdle, StFill: begin
        if (bus.wr_en) begin
          mem_we     = 1'b1;
          wr_ptr_d   = wr_ptr_q + PtrOne;
          fill_cnt_d = fill_cnt_q + CntOne;
          state_d    = (fill_cnt_d == DepthCnt) ? StFull : StFill;
        end
        if (bus.trgg_start_read) begin
          if (state_q == StIdle) rdy_d = 1'b1;
          else                   start_read = 1'b1;
        end
      end
      StFull: begin
        if (bus.wr_en) overflow_d = 1'b1;
        if (bus.trgg_start_read) start_read = 1'b1;
      end
      StRead: begin
        rd_addr = rd_next[ADR_WIDTH-1:0];
        if (rd_next < fill_cnt_q) begin
          ram_vld_d  = 1'b1;
          ram_last_d = (rd_next + CntOne == fill_cnt_q);
          rd_ptr_d   = rd_next[ADR_WIDTH-1:0];
        end
        if (rdy_q) begin
          state_d    = StIdle;
          wr_ptr_d   = '0;
          rd_ptr_d   = '0;
          fill_cnt_d = '0;
          overflow_d = 1'b0;
        end
      end
    endcase

    if (start_read) begin
      state_d    = StRead;
      rd_ptr_d   = '0;
      ram_vld_d  = 1'b1;
      ram_last_d = (fill_cnt_d == CntOne);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q      <= StIdle;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fill_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      rdy_q        <= 1'b0;
      ram_vld_q    <= 1'b0;
      ram_last_q   <= 1'b0;
      data_valid_q <= 1'b0;
      data_out_q   <= '0;
    end else if (bus.en) begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fill_cnt_q   <= fill_cnt_d;
      overflow_q   <= overflow_d;
      rdy_q        <= rdy_d;
      ram_vld_q    <= ram_vld_d;
      ram_last_q   <= ram_last_d;
      data_valid_q <= data_valid_d;
      data_out_q   <= data_out_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.data_head  = (BITWIDTH_HEAD-6)'(HeadWord);
  assign bus.fill_cnt   = fill_cnt_q;
  assign bus.full       = (fill_cnt_q == DepthCnt);
  assign bus.overflow   = overflow_q;
  assign bus.rdy        = rdy_q;
endmodule

// File: tb/tb_skeleton_ram_capture.sv
// Scoreboard bench for skeleton_ram_capture with DEPTH=8 and 12-bit words on a 16-bit bus.
module tb_skeleton_ram_capture;
  localparam int unsigned AW = 3;
  localparam logic [25:0] HeadExp = 26'b0100_000000_000011_00000_01100;

  typedef struct {
    logic [15:0] data;
    logic        last;
  } exp_t;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;
  logic en_at_edge;
  exp_t exp_q[$];
  logic [15:0] model[$];
  logic [15:0] held;

  skeleton_ram_capture_if #(.BITWIDTH_SYS(16), .BITWIDTH_HEAD(32), .ADR_WIDTH(AW)) bus ();

  skeleton_ram_capture #(
    .BITWIDTH_IN   (12),
    .BITWIDTH_SYS  (16),
    .BITWIDTH_HEAD (32),
    .ADR_WIDTH     (AW)
  ) dut (
    .clk_sys (clk),
    .rst     (rst),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endfunction

  always @(posedge clk) en_at_edge = bus.en;

  // Monitor: every freshly presented readback word is matched against the queue.
  always @(negedge clk) begin
    if (bus.data_valid && en_at_edge) begin
      if (exp_q.size() == 0) begin
        chk("spurious data_valid", 32'(bus.data_out), 32'hDEAD);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("readback data", 32'(bus.data_out), 32'(e.data));
        chk("rdy with word", 32'(bus.rdy), 32'(e.last));
      end
    end
  end

  task automatic wr(input logic [15:0] d);
    bus.wr_en = 1'b1;
    bus.data_in = d;
    if (model.size() < 8) model.push_back(d & 16'hFFF0);
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic push_expected();
    for (int i = 0; i < model.size(); i++) begin
      exp_t e;
      e.data = model[i];
      e.last = (i == model.size() - 1);
      exp_q.push_back(e);
    end
    model.delete();
  endtask

  task automatic trig(input logic with_wr, input logic [15:0] d);
    bus.trgg_start_read = 1'b1;
    bus.wr_en = with_wr;
    bus.data_in = d;
    if (with_wr && model.size() < 8) model.push_back(d & 16'hFFF0);
    push_expected();
    @(negedge clk);
    bus.trgg_start_read = 1'b0;
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_rdy(input string name);
    int i;
    i = 0;
    while (!bus.rdy && i < 40) begin
      @(negedge clk);
      i++;
    end
    chk({name, " rdy seen"}, 32'(bus.rdy), 32'd1);
    @(negedge clk);
    chk({name, " fill_cnt cleared"}, 32'(bus.fill_cnt), 32'd0);
    chk({name, " valid dropped"}, 32'(bus.data_valid), 32'd0);
    chk({name, " overflow cleared"}, 32'(bus.overflow), 32'd0);
    chk({name, " full cleared"}, 32'(bus.full), 32'd0);
    chk({name, " head"}, 32'(bus.data_head), 32'(HeadExp));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    bus.en = 1'b1;
    bus.wr_en = 1'b0;
    bus.trgg_start_read = 1'b0;
    bus.data_in = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("reset fill_cnt", 32'(bus.fill_cnt), 32'd0);
    chk("reset data_out", 32'(bus.data_out), 32'd0);
    chk("reset valid", 32'(bus.data_valid), 32'd0);
    chk("reset rdy", 32'(bus.rdy), 32'd0);
    chk("reset full", 32'(bus.full), 32'd0);
    chk("reset overflow", 32'(bus.overflow), 32'd0);
    chk("reset head", 32'(bus.data_head), 32'(HeadExp));

    // 1: three words with latency check
    wr(16'hABC0); chk("t1 fill 1", 32'(bus.fill_cnt), 32'd1);
    wr(16'h1230); chk("t1 fill 2", 32'(bus.fill_cnt), 32'd2);
    wr(16'hFFF0); chk("t1 fill 3", 32'(bus.fill_cnt), 32'd3);
    trig(1'b0, 16'h0);
    chk("t1 no valid at t+1", 32'(bus.data_valid), 32'd0);
    @(negedge clk);
    chk("t1 valid at t+2", 32'(bus.data_valid), 32'd1);
    wait_rdy("t1");

    // 2: overflow past 8 words
    for (int i = 1; i <= 10; i++) begin
      wr(16'(i * 16));
      if (i == 7) chk("t2 not full at 7", 32'(bus.full), 32'd0);
      if (i == 8) chk("t2 full at 8", 32'(bus.full), 32'd1);
      if (i == 8) chk("t2 no overflow at 8", 32'(bus.overflow), 32'd0);
      if (i == 9) chk("t2 overflow at 9", 32'(bus.overflow), 32'd1);
    end
    chk("t2 fill 8", 32'(bus.fill_cnt), 32'd8);
    trig(1'b0, 16'h0);
    wait_rdy("t2");

    // 3: trigger on empty buffer
    trig(1'b0, 16'h0);
    chk("t3 rdy pulse", 32'(bus.rdy), 32'd1);
    @(negedge clk);
    chk("t3 rdy single", 32'(bus.rdy), 32'd0);
    chk("t3 fill stays 0", 32'(bus.fill_cnt), 32'd0);

    // 4: EN freeze during readback
    wr(16'h1110); wr(16'h2220); wr(16'h3330); wr(16'h4440);
    trig(1'b0, 16'h0);
    repeat (2) @(negedge clk);
    #1;
    held = bus.data_out;
    chk("t4 second word", 32'(held), 32'h2220);
    bus.en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("t4 data_out hold", 32'(bus.data_out), 32'(held));
      chk("t4 valid hold", 32'(bus.data_valid), 32'd1);
      chk("t4 no rdy", 32'(bus.rdy), 32'd0);
    end
    bus.en = 1'b1;
    wait_rdy("t4");

    // 5: reset mid-readback
    wr(16'h0110); wr(16'h0220); wr(16'h0330); wr(16'h0440); wr(16'h0550);
    trig(1'b0, 16'h0);
    repeat (2) @(negedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk("t5 valid after rst", 32'(bus.data_valid), 32'd0);
    chk("t5 data_out after rst", 32'(bus.data_out), 32'd0);
    chk("t5 rdy after rst", 32'(bus.rdy), 32'd0);
    chk("t5 fill after rst", 32'(bus.fill_cnt), 32'd0);
    @(negedge clk);
    chk("t5 still no rdy", 32'(bus.rdy), 32'd0);
    wr(16'h5550);
    trig(1'b0, 16'h0);
    wait_rdy("t5");

    // 6: write in trigger cycle, then write during READ ignored
    wr(16'h6660); wr(16'h6670);
    trig(1'b1, 16'h7770);
    bus.wr_en = 1'b1;
    bus.data_in = 16'h9990;
    @(negedge clk);
    bus.wr_en = 1'b0;
    chk("t6 fill ignores read-time write", 32'(bus.fill_cnt), 32'd3);
    wait_rdy("t6");

    repeat (3) @(negedge clk);
    chk("queue drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
